// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: byte-write handshake into the UART transmit FIFO.
//   tx_vld  : producer has a byte on tx_data
//   tx_data : byte to send, sampled only on acceptance
//   tx_rdy  : FIFO has room
// Handshake: a byte is transferred on a rising clk edge where tx_vld && tx_rdy.
// tx_rdy does not depend on tx_vld. When tx_rdy is low, tx_vld is ignored:
// nothing is stored and nothing is flagged.
`timescale 1ns/1ps
interface uart_tx_fifo_if;
  logic       tx_vld;
  logic [7:0] tx_data;
  logic       tx_rdy;

  modport master (output tx_vld, output tx_data, input tx_rdy);
  modport slave  (input tx_vld, input tx_data, output tx_rdy);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter (LSB first) fed by a small byte FIFO.
// It returns result bytes to the host. Each bit lasts DIV_CNT+1 clk cycles.
// Ports:
//   clk       : system clock
//   rst       : asynchronous, active-high reset
//   bus       : write handshake (slave side): tx_vld, tx_data, tx_rdy
//   tx_busy   : high while a frame is in flight or the FIFO holds data
//   tx        : serial line, registered, idles high
//   dbg_state : current FSM state (0 IDLE, 1 START, 2 DATA, 3 STOP)
`timescale 1ns/1ps
module uart_tx_fifo #(
  parameter logic [9:0] DIV_CNT = 10'd867,
  parameter int         FIFO_AW = 2
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_fifo_if.slave    bus,
  output logic             tx_busy,
  output logic             tx,
  output logic [1:0]       dbg_state
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] FULL = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;

  state_t             state;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic [9:0]         div_cnt;
  logic [2:0]         bit_cnt;
  logic [7:0]         shift;
  logic               wr_en;
  logic               pop;
  logic               bit_end;
  logic               fifo_ne;

  // tx_rdy comes from the registered count only, so a pop in the same
  // cycle never unblocks a write while full.
  assign bus.tx_rdy = (count != FULL);
  assign wr_en      = bus.tx_vld && bus.tx_rdy;
  assign fifo_ne    = (count != '0);
  assign bit_end    = (div_cnt == DIV_CNT);
  // The pop decision uses the registered count: a byte written in the
  // same cycle is picked up by the next decision.
  assign pop        = fifo_ne && ((state == IDLE) || ((state == STOP) && bit_end));

  assign tx_busy   = (state != IDLE) || fifo_ne;
  assign dbg_state = state;

  // FIFO storage needs no reset; count and pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= bus.tx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // tx is loaded with the level of the state/bit being entered, so line
  // edges coincide with state changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      div_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      div_cnt <= ((state == IDLE) || bit_end) ? 10'd0 : div_cnt + 10'd1;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift <= mem[rd_ptr];
            state <= START;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            bit_cnt <= '0;
            state   <= DATA;
            tx      <= shift[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              shift   <= shift >> 1;
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= shift[1];
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            if (pop) begin
              // back-to-back frame: no idle gap after the stop bit
              shift <= mem[rd_ptr];
              state <= START;
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: bench for uart_tx_fifo with DIV_CNT=3 (4 cycles per bit)
// and a 4-byte FIFO. A line monitor decodes frames mid-bit and compares them
// with the expected-frame queue filled when bytes are written.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
  localparam logic [9:0] DIV = 10'd3;
  localparam int BIT_CYC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_busy;
  logic       tx;
  logic [1:0] dbg_state;
  logic       mon_en;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [9:0] exp_q[$];
  int         start_q[$];

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;   // line bits, [0]=start ... [9]=stop
  } vec_t;

  uart_tx_fifo_if bus();

  uart_tx_fifo #(.DIV_CNT(DIV), .FIFO_AW(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .tx_busy(tx_busy),
    .tx(tx),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [9:0] frame_of(input logic [7:0] d);
    return {1'b1, d, 1'b0};
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic raw_write(input logic [7:0] d, output logic ok);
    int n = 0;
    while (!bus.tx_rdy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    ok = (n < 2000);
    if (ok) begin
      bus.tx_vld  = 1'b1;
      bus.tx_data = d;
      @(posedge clk);
      @(negedge clk);
      bus.tx_vld = 1'b0;
    end
  endtask

  task automatic push_byte(input logic [7:0] d, input logic [9:0] frame);
    logic ok;
    raw_write(d, ok);
    check("write rdy timeout", ok, 1);
    if (ok) exp_q.push_back(frame);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || tx_busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({name, " drain"}, (n < 5000), 1);
    repeat (3) @(negedge clk);
  endtask

  // ---------------- line monitor / scoreboard ----------------
  initial begin : monitor
    logic [9:0] fr;
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (mon_en && !rst && tx == 1'b0) begin
        start_q.push_back(cyc);
        @(negedge clk);            // middle of the start bit
        fr[0] = tx;
        for (int i = 1; i < 10; i++) begin
          repeat (BIT_CYC) @(negedge clk);
          fr[i] = tx;
        end
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL frame: got %0h expected none", fr);
        end else begin
          e = exp_q.pop_front();
          check("frame", fr, e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : main
    vec_t       vecs[6];
    logic [9:0] t1_pat;
    logic [7:0] d;
    logic       ok;
    logic       rdy_s;
    int         acc;
    int         k;

    vecs[0] = '{8'h00, 10'b1_00000000_0};
    vecs[1] = '{8'hFF, 10'b1_11111111_0};
    vecs[2] = '{8'h55, 10'b1_01010101_0};
    vecs[3] = '{8'h3C, 10'b1_00111100_0};
    vecs[4] = '{8'h81, 10'b1_10000001_0};
    vecs[5] = '{8'h6A, 10'b1_01101010_0};

    rst = 1'b1;
    mon_en = 1'b1;
    bus.tx_vld = 1'b0;
    bus.tx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("reset tx", tx, 1);
    check("reset rdy", bus.tx_rdy, 1);
    check("reset busy", tx_busy, 0);
    check("reset state", dbg_state, 0);
    rst = 1'b0;
    @(negedge clk);

    // T1: 0xA5, cycle-exact line and busy
    t1_pat = 10'b1_10100101_0;
    bus.tx_vld = 1'b1;
    bus.tx_data = 8'hA5;
    @(posedge clk);                     // edge 0
    exp_q.push_back(t1_pat);
    @(negedge clk);
    bus.tx_vld = 1'b0;
    for (int c = 1; c <= 41; c++) begin
      @(negedge clk);
      if (c <= 40) check($sformatf("t1 tx c%0d", c), tx, t1_pat[(c - 1) / 4]);
      if (c == 40) check("t1 busy c40", tx_busy, 1);
      if (c == 41) check("t1 busy c41", tx_busy, 0);
    end
    wait_drain("t1");

    // table vectors, written back-to-back
    for (int i = 0; i < 6; i++) push_byte(vecs[i].data, vecs[i].frame);
    wait_drain("table");

    // random bytes
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom_range(0, 255));
      push_byte(d, frame_of(d));
    end
    wait_drain("random");

    // T3: hold tx_vld, fill FIFO, 6th byte after frame 1 pops
    d = 8'h00;
    acc = 0;
    k = 0;
    bus.tx_vld = 1'b1;
    bus.tx_data = d;
    while (acc < 6 && k < 200) begin
      rdy_s = bus.tx_rdy;
      @(posedge clk);                   // edge k
      if (rdy_s) begin
        exp_q.push_back(frame_of(d));
        if (acc == 4) check("t3 fifth edge", k, 4);
        if (acc == 5) check("t3 sixth edge", k, 42);
        acc++;
        d = d + 8'd1;
      end
      @(negedge clk);                   // cycle k
      bus.tx_data = d;
      if (k == 4)  check("t3 rdy c4", bus.tx_rdy, 0);
      if (k == 40) check("t3 rdy c40", bus.tx_rdy, 0);
      if (k == 41) check("t3 rdy c41", bus.tx_rdy, 1);
      k++;
    end
    bus.tx_vld = 1'b0;
    check("t3 accepted", acc, 6);

    // T4: write 0xEE while full is dropped
    check("t4 rdy before", bus.tx_rdy, 0);
    bus.tx_vld = 1'b1;
    bus.tx_data = 8'hEE;
    @(posedge clk);
    @(negedge clk);
    bus.tx_vld = 1'b0;
    check("t4 rdy after", bus.tx_rdy, 0);
    wait_drain("t3t4");

    // T5: reset during DATA bit 3 of 0x34 with 0x77 queued behind it
    mon_en = 1'b0;
    raw_write(8'h34, ok);               // accepted at edge N
    check("t5 write a", ok, 1);
    raw_write(8'h77, ok);
    check("t5 write b", ok, 1);
    repeat (16) @(negedge clk);         // cycle N+17: DATA bit 3
    check("t5 state data", dbg_state, 2);
    check("t5 tx bit3", tx, 0);
    rst = 1'b1;
    #1;
    check("t5 async tx", tx, 1);
    check("t5 async rdy", bus.tx_rdy, 1);
    check("t5 async busy", tx_busy, 0);
    check("t5 async state", dbg_state, 0);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    check("t5 fifo cleared", tx_busy, 0);
    push_byte(8'h81, 10'b1_10000001_0);
    wait_drain("t5");
    repeat (50) @(negedge clk);
    check("t5 no stale frame", tx_busy, 0);
    check("t5 line idle", tx, 1);

    // T6: back-to-back spacing
    start_q.delete();
    push_byte(8'h01, 10'b1_00000001_0);
    push_byte(8'h80, 10'b1_10000000_0);
    wait_drain("t6");
    check("t6 frames", start_q.size(), 2);
    if (start_q.size() == 2) check("t6 spacing", start_q[1] - start_q[0], 40);
    check("end queue empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
